vc_fifo_param: RTL and testbench

VC_FIFO_PARAM -- requirements
Module: vc_fifo_param

---
 rtl/vc_fifo_param_if.sv | 35 +++
 rtl/vc_fifo_param.sv | 96 +++++++++
 tb/tb_vc_fifo_param.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_fifo_param_if.sv
// Handshake and status bundle for vc_fifo_param.
// Pure signal grouping, no logic or latency of its own.
// master drives write/read requests; slave returns data and status.
interface vc_fifo_param_if #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
);
  logic              wr_enable;
  logic              rd_enable;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W:0]   af_thr;
  logic [ADDR_W:0]   ae_thr;
  logic              err_clear;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   fill_count;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output wr_enable, rd_enable, data_in, af_thr, ae_thr, err_clear,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           fill_count, overflow_err, underflow_err
  );

  modport slave (
    input  wr_enable, rd_enable, data_in, af_thr, ae_thr, err_clear,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           fill_count, overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_param.sv
// Synchronous FIFO with thresholds, sticky error flags and registered read data.
// Read data appears one cycle after an accepted read; status flags are combinational.
// Writes to a full FIFO are dropped unless a read frees a slot the same cycle.
module vc_fifo_param #(
  parameter int DATA_W    = 6,
  parameter int ADDR_W    = 2,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  vc_fifo_param_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ovf_err;
  logic              unf_err;

  logic              is_full;
  logic              is_empty;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W:0]   af_sat;
  logic [ADDR_W:0]   ae_sat;

  // Acceptance and flags; a read frees a slot for a write at full, but a
  // write never makes an empty FIFO readable in the same cycle.
  always_comb begin
    is_full  = (count == DEPTH_C);
    is_empty = (count == '0);
    rd_acc   = bus.rd_enable & ~is_empty;
    wr_acc   = bus.wr_enable & (~is_full | rd_acc);
    af_sat   = (bus.af_thr > DEPTH_C) ? DEPTH_C : bus.af_thr;
    ae_sat   = (bus.ae_thr > DEPTH_C) ? DEPTH_C : bus.ae_thr;
  end

  // Storage array is not reset; writes are suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy, read data register and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end else if (ZERO_IDLE) begin
        rd_data <= '0;
      end
      // A new error event in the same cycle as err_clear keeps the flag set.
      ovf_err <= (bus.wr_enable & ~wr_acc) | (ovf_err & ~bus.err_clear);
      unf_err <= (bus.rd_enable & is_empty) | (unf_err & ~bus.err_clear);
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.data_out      = rd_data;
    bus.data_valid    = rd_valid;
    bus.full          = is_full;
    bus.empty         = is_empty;
    bus.almost_full   = (count >= (DEPTH_C - af_sat));
    bus.almost_empty  = (count <= ae_sat);
    bus.fill_count    = count;
    bus.overflow_err  = ovf_err;
    bus.underflow_err = unf_err;
  end
endmodule

// File: tb/tb_vc_fifo_param.sv
// Scenario bench for vc_fifo_param (DATA_W=6, ADDR_W=2, ZERO_IDLE=1).
// Expected read words are queued when a read is issued and popped when data_valid is due.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vc_fifo_param;
  logic clk = 1'b0;
  logic reset;

  vc_fifo_param_if #(.DATA_W(6), .ADDR_W(2)) bus();

  vc_fifo_param #(.DATA_W(6), .ADDR_W(2), .ZERO_IDLE(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] mq[$];   // reference FIFO contents
  logic [5:0] sb[$];   // expected read words, oldest first
  bit         rd_pending;

  // Apply one cycle of stimulus and advance the reference FIFO.
  task automatic drive(input bit rst, input bit we, input bit re,
                       input logic [5:0] d, input bit clr);
    bit ra, wa;
    reset         = rst;
    bus.wr_enable = we;
    bus.rd_enable = re;
    bus.data_in   = d;
    bus.err_clear = clr;
    if (rst) begin
      mq.delete();
      sb.delete();
      rd_pending = 1'b0;
    end else begin
      ra = re && (mq.size() != 0);
      wa = we && ((mq.size() != 4) || ra);
      rd_pending = ra;
      if (ra) sb.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
    reset = 1'b0;
    n_checks++;
    if (bus.fill_count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b af=%b, want cnt=0 e=1 f=0 ae=1 af=0",
               bus.fill_count, bus.empty, bus.full, bus.almost_empty, bus.almost_full);
    end
    n_checks++;
    if (bus.data_out !== 6'h00 || bus.data_valid !== 1'b0 ||
        bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: dout=%h dv=%b ovf=%b unf=%b, want all 0",
               bus.data_out, bus.data_valid, bus.overflow_err, bus.underflow_err);
    end
    // af_thr above DEPTH saturates to DEPTH, so almost_full holds at count 0.
    bus.af_thr = 3'd7;
    #1;
    n_checks++;
    if (bus.almost_full !== 1'b1) begin
      n_fail++;
      $display("FAIL af_saturate: almost_full=%b, want 1", bus.almost_full);
    end
    bus.af_thr = 3'd1;
    #1;
  endtask

  task automatic test_fill_drain();
    logic [5:0] exp;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 6'(i), 1'b0);
      n_checks++;
      if (bus.fill_count !== 3'(i) || bus.full !== (i == 4) ||
          bus.almost_full !== (i >= 3) || bus.almost_empty !== (i <= 1)) begin
        n_fail++;
        $display("FAIL fill_%0d: cnt=%0d f=%b af=%b ae=%b, want cnt=%0d f=%b af=%b ae=%b",
                 i, bus.fill_count, bus.full, bus.almost_full, bus.almost_empty,
                 i, (i == 4), (i >= 3), (i <= 1));
      end
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
      if (rd_pending) begin
        exp = sb.pop_front();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
          n_fail++;
          $display("FAIL drain_%0d: dv=%b dout=%h, want dv=1 dout=%h", i, bus.data_valid, bus.data_out, exp);
        end
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.fill_count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: e=%b cnt=%0d, want e=1 cnt=0", bus.empty, bus.fill_count);
    end
    drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
    n_checks++;
    if (bus.data_valid !== 1'b0 || bus.data_out !== 6'h00) begin
      n_fail++;
      $display("FAIL idle_zero: dv=%b dout=%h, want dv=0 dout=00", bus.data_valid, bus.data_out);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 6'h11 + 6'(i), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'h3F, 1'b0);
    n_checks++;
    if (bus.overflow_err !== 1'b1 || bus.fill_count !== 3'd4 || bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b cnt=%0d unf=%b, want ovf=1 cnt=4 unf=0",
               bus.overflow_err, bus.fill_count, bus.underflow_err);
    end
    drive(1'b0, 1'b1, 1'b0, 6'h3F, 1'b1);
    n_checks++;
    if (bus.overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: ovf=%b, want 1", bus.overflow_err);
    end
    drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    n_checks++;
    if (bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b, want 0", bus.overflow_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
      if (rd_pending) begin
        exp = sb.pop_front();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
          n_fail++;
          $display("FAIL ovf_drain_%0d: dv=%b dout=%h, want dv=1 dout=%h", i, bus.data_valid, bus.data_out, exp);
        end
      end
    end
  endtask

  task automatic test_underflow();
    logic [5:0] exp;
    drive(1'b0, 1'b1, 1'b1, 6'h15, 1'b0);
    n_checks++;
    if (bus.underflow_err !== 1'b1 || bus.fill_count !== 3'd1 ||
        bus.data_valid !== 1'b0 || bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_set: unf=%b cnt=%0d dv=%b ovf=%b, want unf=1 cnt=1 dv=0 ovf=0",
               bus.underflow_err, bus.fill_count, bus.data_valid, bus.overflow_err);
    end
    drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
    if (rd_pending) begin
      exp = sb.pop_front();
      n_checks++;
      if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
        n_fail++;
        $display("FAIL unf_read: dv=%b dout=%h, want dv=1 dout=%h", bus.data_valid, bus.data_out, exp);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    n_checks++;
    if (bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_clear: unf=%b, want 0", bus.underflow_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 6'h21 + 6'(i), 1'b0);
    // ae_thr above DEPTH saturates, so almost_empty holds even when full.
    bus.ae_thr = 3'd7;
    #1;
    n_checks++;
    if (bus.almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ae_saturate: almost_empty=%b, want 1", bus.almost_empty);
    end
    bus.ae_thr = 3'd1;
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 6'h2A, 1'b0);
      n_checks++;
      if (bus.fill_count !== 3'd4 || bus.overflow_err !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_cnt_%0d: cnt=%0d ovf=%b, want cnt=4 ovf=0", i, bus.fill_count, bus.overflow_err);
      end
      if (rd_pending) begin
        exp = sb.pop_front();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
          n_fail++;
          $display("FAIL b2b_rd_%0d: dv=%b dout=%h, want dv=1 dout=%h", i, bus.data_valid, bus.data_out, exp);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
      if (rd_pending) begin
        exp = sb.pop_front();
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
          n_fail++;
          $display("FAIL b2b_drain_%0d: dv=%b dout=%h, want dv=1 dout=%h", i, bus.data_valid, bus.data_out, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    drive(1'b0, 1'b1, 1'b0, 6'h31, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'h32, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 6'h33, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
    if (rd_pending) begin
      exp = sb.pop_front();
      n_checks++;
      if (bus.data_out !== exp) begin
        n_fail++;
        $display("FAIL mid_pre_read: dout=%h, want %h", bus.data_out, exp);
      end
    end
    drive(1'b1, 1'b1, 1'b1, 6'h3F, 1'b0);
    n_checks++;
    if (bus.fill_count !== 3'd0 || bus.empty !== 1'b1 || bus.data_out !== 6'h00 ||
        bus.data_valid !== 1'b0 || bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: cnt=%0d e=%b dout=%h dv=%b ovf=%b unf=%b, want 0 1 00 0 0 0",
               bus.fill_count, bus.empty, bus.data_out, bus.data_valid,
               bus.overflow_err, bus.underflow_err);
    end
    drive(1'b0, 1'b1, 1'b0, 6'h07, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 6'h00, 1'b0);
    n_checks++;
    if (!rd_pending || bus.data_valid !== 1'b1 || bus.data_out !== 6'h07) begin
      n_fail++;
      $display("FAIL mid_after: dv=%b dout=%h, want dv=1 dout=07", bus.data_valid, bus.data_out);
    end
    if (rd_pending) void'(sb.pop_front());
  endtask

  task automatic test_random();
    logic [5:0] exp;
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom), 1'b0);
      n_checks++;
      if (bus.fill_count !== 3'(mq.size()) || bus.full !== (mq.size() == 4) ||
          bus.empty !== (mq.size() == 0)) begin
        n_fail++;
        $display("FAIL rnd_cnt_%0d: cnt=%0d f=%b e=%b, want cnt=%0d", i, bus.fill_count,
                 bus.full, bus.empty, mq.size());
      end
      n_checks++;
      if (rd_pending) begin
        exp = sb.pop_front();
        if (bus.data_valid !== 1'b1 || bus.data_out !== exp) begin
          n_fail++;
          $display("FAIL rnd_rd_%0d: dv=%b dout=%h, want dv=1 dout=%h", i, bus.data_valid, bus.data_out, exp);
        end
      end else if (bus.data_valid !== 1'b0 || bus.data_out !== 6'h00) begin
        n_fail++;
        $display("FAIL rnd_idle_%0d: dv=%b dout=%h, want dv=0 dout=00", i, bus.data_valid, bus.data_out);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 6'h00, 1'b1);
    n_checks++;
    if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_clear: ovf=%b unf=%b, want 0 0", bus.overflow_err, bus.underflow_err);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in   = 6'h00;
    bus.af_thr    = 3'd1;
    bus.ae_thr    = 3'd1;
    bus.err_clear = 1'b0;
    rd_pending    = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
